// File: rtl/sts_gen.sv
// rtl/sts_gen.sv - 802.11a short training sequence generator
//
// Emits the 16-sample STS period, repeated a programmable number of times,
// one complex sample per downstream pull.
//
// Ports:
//   clock               system clock
//   reset               synchronous, active-high reset
//   i_enable            global enable; low freezes all state
//   i_set_stb           setting bus strobe
//   i_set_addr[7:0]     setting bus address
//   i_set_data[31:0]    setting bus data
//   i_start             one-cycle request to begin a burst
//   i_sample_req        one-cycle pull for the next sample
//   o_sample_out[31:0]  I in [31:16], Q in [15:0], signed 16-bit each
//   o_sample_out_strobe o_sample_out valid, one cycle
//   o_busy              burst in progress
//   o_done              one-cycle pulse with the final sample, or alone
//                       for an empty burst

module sts_gen #(
   parameter logic [7:0] SR_STS_REPEAT = 8'd40,
   parameter logic [7:0] SR_STS_SHIFT  = 8'd41
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_enable,
   input  logic        i_set_stb,
   input  logic [7:0]  i_set_addr,
   input  logic [31:0] i_set_data,
   input  logic        i_start,
   input  logic        i_sample_req,
   output logic [31:0] o_sample_out,
   output logic        o_sample_out_strobe,
   output logic        o_busy,
   output logic        o_done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t             r_state;
   logic [7:0]         r_sts_repeat;
   logic [2:0]         r_sts_shift;
   logic [7:0]         r_repeat_l;
   logic [2:0]         r_shift_l;
   logic [3:0]         r_idx;
   logic [7:0]         r_rep;
   logic               r_empty;

   logic signed [15:0] w_rom_i;
   logic signed [15:0] w_rom_q;
   logic signed [15:0] w_i;
   logic signed [15:0] w_q;
   logic               w_first;
   logic [3:0]         w_shift;
   logic               w_unused;

   // Only the low byte / low three bits of the setting data are meaningful.
   assign w_unused = &{1'b0, i_set_data[31:8], i_set_data[7:3]};

   // Setting registers live outside the enable domain so software can
   // program them at any time; a burst only sees them through the copies
   // latched at start.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sts_repeat <= 8'd10;
         r_sts_shift  <= 3'd0;
      end else if (i_set_stb) begin
         if (i_set_addr == SR_STS_REPEAT)
            r_sts_repeat <= i_set_data[7:0];
         if (i_set_addr == SR_STS_SHIFT)
            r_sts_shift <= i_set_data[2:0];
      end
   end

   // STS values scaled by 16384.
   always_comb begin
      w_rom_i = 16'sd0;
      w_rom_q = 16'sd0;
      case (r_idx)
         4'd0:  begin w_rom_i =  16'sd754;  w_rom_q =  16'sd754;  end
         4'd1:  begin w_rom_i = -16'sd2163; w_rom_q =  16'sd33;   end
         4'd2:  begin w_rom_i = -16'sd213;  w_rom_q = -16'sd1294; end
         4'd3:  begin w_rom_i =  16'sd2343; w_rom_q = -16'sd213;  end
         4'd4:  begin w_rom_i =  16'sd1507; w_rom_q =  16'sd0;    end
         4'd5:  begin w_rom_i =  16'sd2343; w_rom_q = -16'sd213;  end
         4'd6:  begin w_rom_i = -16'sd213;  w_rom_q = -16'sd1294; end
         4'd7:  begin w_rom_i = -16'sd2163; w_rom_q =  16'sd33;   end
         4'd8:  begin w_rom_i =  16'sd754;  w_rom_q =  16'sd754;  end
         4'd9:  begin w_rom_i =  16'sd33;   w_rom_q = -16'sd2163; end
         4'd10: begin w_rom_i = -16'sd1294; w_rom_q = -16'sd213;  end
         4'd11: begin w_rom_i = -16'sd213;  w_rom_q =  16'sd2343; end
         4'd12: begin w_rom_i =  16'sd0;    w_rom_q =  16'sd1507; end
         4'd13: begin w_rom_i = -16'sd213;  w_rom_q =  16'sd2343; end
         4'd14: begin w_rom_i = -16'sd1294; w_rom_q = -16'sd213;  end
         4'd15: begin w_rom_i =  16'sd33;   w_rom_q = -16'sd2163; end
         default: begin w_rom_i = 16'sd0;   w_rom_q = 16'sd0;     end
      endcase
   end

   // The very first sample of a burst is halved as the window edge, so it
   // gets one extra bit of arithmetic shift on top of the attenuation.
   assign w_first = (r_rep == 8'd0) && (r_idx == 4'd0);
   assign w_shift = {1'b0, r_shift_l} + {3'b000, w_first};
   assign w_i     = w_rom_i >>> w_shift;
   assign w_q     = w_rom_q >>> w_shift;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state             <= S_IDLE;
         r_repeat_l          <= 8'd0;
         r_shift_l           <= 3'd0;
         r_idx               <= 4'd0;
         r_rep               <= 8'd0;
         r_empty             <= 1'b0;
         o_sample_out        <= 32'd0;
         o_sample_out_strobe <= 1'b0;
         o_busy              <= 1'b0;
         o_done              <= 1'b0;
      end else if (i_enable) begin
         o_sample_out_strobe <= 1'b0;
         o_done              <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_repeat_l <= r_sts_repeat;
                  r_shift_l  <= r_sts_shift;
                  r_idx      <= 4'd0;
                  r_rep      <= 8'd0;
                  o_busy     <= 1'b1;
                  // An empty burst passes through DONE with busy set for
                  // one cycle and raises done on the way out.
                  if (r_sts_repeat == 8'd0) begin
                     r_state <= S_DONE;
                     r_empty <= 1'b1;
                  end else begin
                     r_state <= S_RUN;
                     r_empty <= 1'b0;
                  end
               end
            end
            S_RUN: begin
               if (i_sample_req) begin
                  o_sample_out        <= {w_i, w_q};
                  o_sample_out_strobe <= 1'b1;
                  r_idx               <= r_idx + 4'd1;
                  if (r_idx == 4'd15) begin
                     r_rep <= r_rep + 8'd1;
                     // done rides with the final strobe; DONE then only
                     // spends a cycle before returning to IDLE.
                     if (r_rep == r_repeat_l - 8'd1) begin
                        r_state <= S_DONE;
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                     end
                  end
               end
            end
            S_DONE: begin
               o_done  <= r_empty;
               o_busy  <= 1'b0;
               r_empty <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               o_busy  <= 1'b0;
            end
         endcase
      end else begin
         o_sample_out_strobe <= 1'b0;
         o_done              <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sts_gen.sv
// tb/tb_sts_gen.sv - directed self-checking bench for sts_gen

module tb_sts_gen;

   localparam logic [7:0] A_REP = 8'd40;
   localparam logic [7:0] A_SH  = 8'd41;

   logic        clock;
   logic        reset;
   logic        i_enable;
   logic        i_set_stb;
   logic [7:0]  i_set_addr;
   logic [31:0] i_set_data;
   logic        i_start;
   logic        i_sample_req;
   logic [31:0] o_sample_out;
   logic        o_sample_out_strobe;
   logic        o_busy;
   logic        o_done;

   int n_cmp = 0;
   int n_err = 0;
   int n_strobe = 0;

   int rom_i[16] = '{754, -2163, -213, 2343, 1507, 2343, -213, -2163,
                     754, 33, -1294, -213, 0, -213, -1294, 33};
   int rom_q[16] = '{754, 33, -1294, -213, 0, -213, -1294, 33,
                     754, -2163, -213, 2343, 1507, 2343, -213, -2163};

   sts_gen #(.SR_STS_REPEAT(A_REP), .SR_STS_SHIFT(A_SH)) dut (
      .clock               (clock),
      .reset               (reset),
      .i_enable            (i_enable),
      .i_set_stb           (i_set_stb),
      .i_set_addr          (i_set_addr),
      .i_set_data          (i_set_data),
      .i_start             (i_start),
      .i_sample_req        (i_sample_req),
      .o_sample_out        (o_sample_out),
      .o_sample_out_strobe (o_sample_out_strobe),
      .o_busy              (o_busy),
      .o_done              (o_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) if (o_sample_out_strobe) n_strobe++;

   function automatic logic [31:0] pk(int a, int b);
      return {a[15:0], b[15:0]};
   endfunction

   function automatic logic [31:0] expv(int k, int sh);
      int a;
      int b;
      int s;
      s = sh + ((k == 0) ? 1 : 0);
      a = rom_i[k % 16] >>> s;
      b = rom_q[k % 16] >>> s;
      return {a[15:0], b[15:0]};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(logic [7:0] a, logic [31:0] d);
      i_set_stb  = 1'b1;
      i_set_addr = a;
      i_set_data = d;
      tick();
      i_set_stb  = 1'b0;
   endtask

   task automatic start_burst();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic pull(output logic [31:0] s, output logic st, output logic dn);
      i_sample_req = 1'b1;
      tick();
      s  = o_sample_out;
      st = o_sample_out_strobe;
      dn = o_done;
      i_sample_req = 1'b0;
   endtask

   initial begin
      logic [31:0] s;
      logic        st;
      logic        dn;
      logic [31:0] s0, s1, s3, s16, slast;
      logic        dlast;
      int          bad;
      int          n0;

      reset = 1'b1; i_enable = 1'b1; i_set_stb = 1'b0; i_set_addr = 8'd0;
      i_set_data = 32'd0; i_start = 1'b0; i_sample_req = 1'b0;
      tick(); tick();
      chk("rst_out", o_sample_out, 32'd0);
      chk("rst_flags", {29'd0, o_sample_out_strobe, o_busy, o_done}, 32'd0);
      reset = 1'b0;
      tick();

      // Default settings: 160 samples, pulls 3 cycles apart.
      n0 = n_strobe; bad = 0;
      start_burst();
      chk("t1_busy", {31'd0, o_busy}, 32'd1);
      for (int k = 0; k < 160; k++) begin
         pull(s, st, dn);
         if (!st) bad++;
         if (s !== expv(k, 0)) bad++;
         if (k < 159 && dn) bad++;
         if (k == 0) s0 = s;
         if (k == 1) s1 = s;
         if (k == 16) s16 = s;
         if (k == 159) begin slast = s; dlast = dn; end
         if (k == 159) chk("t1_busy_end", {31'd0, o_busy}, 32'd0);
         tick(); tick();
      end
      chk("t1_s0", s0, pk(377, 377));
      chk("t1_s1", s1, pk(-2163, 33));
      chk("t1_s16", s16, pk(754, 754));
      chk("t1_slast", slast, pk(33, -2163));
      chk("t1_done", {31'd0, dlast}, 32'd1);
      chk("t1_all", bad, 0);
      chk("t1_count", n_strobe - n0, 160);

      // Shift 2, one period, back-to-back pulls.
      wr(A_SH, 32'd2);
      wr(A_REP, 32'd1);
      n0 = n_strobe; bad = 0;
      start_burst();
      i_sample_req = 1'b1;
      for (int k = 0; k < 16; k++) begin
         tick();
         if (!o_sample_out_strobe) bad++;
         if (o_sample_out !== expv(k, 2)) bad++;
         if (k == 0) s0 = o_sample_out;
         if (k == 1) s1 = o_sample_out;
         if (k == 3) s3 = o_sample_out;
         if (k == 15) dlast = o_done;
      end
      i_sample_req = 1'b0;
      tick(); tick();
      chk("t2_s0", s0, pk(94, 94));
      chk("t2_s1", s1, pk(-541, 8));
      chk("t2_s3", s3, pk(585, -54));
      chk("t2_done", {31'd0, dlast}, 32'd1);
      chk("t2_all", bad, 0);
      chk("t2_count", n_strobe - n0, 16);

      // Empty burst.
      wr(A_REP, 32'd0);
      n0 = n_strobe;
      start_burst();
      chk("t3_t1", {30'd0, o_busy, o_done}, 32'd2);
      tick();
      chk("t3_t2", {30'd0, o_busy, o_done}, 32'd1);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      chk("t3_restart", {30'd0, o_busy, o_done}, 32'd2);
      tick(); tick(); tick();
      chk("t3_count", n_strobe - n0, 0);

      // Mid-burst start and enable freeze.
      wr(A_REP, 32'd10);
      wr(A_SH, 32'd0);
      n0 = n_strobe; bad = 0;
      start_burst();
      for (int k = 0; k < 40; k++) begin
         pull(s, st, dn);
         tick();
      end
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      i_enable = 1'b0;
      for (int k = 0; k < 5; k++) begin
         i_sample_req = 1'b1;
         tick();
         if (o_sample_out_strobe || o_done) bad++;
      end
      i_sample_req = 1'b0;
      i_enable = 1'b1;
      chk("t4_frozen", bad, 0);
      chk("t4_busy", {31'd0, o_busy}, 32'd1);
      pull(s, st, dn);
      chk("t4_s41", s, pk(754, 754));
      for (int k = 41; k < 160; k++) begin
         tick();
         pull(s, st, dn);
      end
      chk("t4_done", {31'd0, dn}, 32'd1);
      tick(); tick();
      pull(s, st, dn);
      chk("t4_after_done", {31'd0, st}, 32'd0);
      tick();
      chk("t4_count", n_strobe - n0, 160);

      // Reset mid-burst.
      start_burst();
      for (int k = 0; k < 70; k++) begin
         pull(s, st, dn);
         tick();
      end
      reset = 1'b1;
      tick();
      chk("t5_out", o_sample_out, 32'd0);
      chk("t5_flags", {29'd0, o_sample_out_strobe, o_busy, o_done}, 32'd0);
      reset = 1'b0;
      tick();
      chk("t5_nodone", {31'd0, o_done}, 32'd0);
      start_burst();
      pull(s, st, dn);
      chk("t5_restart", s, pk(377, 377));

      // sample_req in IDLE and alongside start.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      i_sample_req = 1'b1;
      tick();
      chk("t6_idle_req", {31'd0, o_sample_out_strobe}, 32'd0);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      i_sample_req = 1'b0;
      chk("t6_start_req", {30'd0, o_sample_out_strobe, o_busy}, 32'd1);
      pull(s, st, dn);
      chk("t6_first", s, pk(377, 377));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
